// File: rtl/axis_pixel_pack.sv
// Packs one AXI-stream pixel per beat into wide memory words for the VDMA write FIFO,
// flushing partial words at end of line and flagging line-length and early-SOF faults.
module axis_pixel_pack #(
    parameter int DSIZE = 24,
    parameter int OSIZE = 256,
    parameter int NSIZE = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [15:0]      hactive,
    input  logic [DSIZE-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tuser,
    input  logic             s_axis_tlast,
    output logic [OSIZE-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [NSIZE-1:0] o_npix,
    output logic             o_sof,
    output logic             o_eol,
    output logic [15:0]      line_cnt,
    output logic             err_line_len,
    output logic             err_early_sof
);

    localparam int PPW = OSIZE / DSIZE;

    typedef enum logic [0:0] {WAIT_SOF, PACK} state_t;

    state_t           state_q;
    logic [OSIZE-1:0] acc_q;
    logic [NSIZE-1:0] slot_q;
    logic [15:0]      linepix_q;
    logic [15:0]      hact_q;
    logic [15:0]      line_cnt_q;
    logic             sof_pend_q;
    logic [OSIZE-1:0] o_data_q;
    logic             o_valid_q;
    logic [NSIZE-1:0] o_npix_q;
    logic             o_sof_q;
    logic             o_eol_q;
    logic             err_len_q;
    logic             err_sof_q;

    logic             out_free;
    logic             accept;
    logic             sof_beat;
    logic             take;
    logic             early_sof;
    logic             complete;
    logic [NSIZE-1:0] slot_d;
    logic [15:0]      linepix_d;
    logic [15:0]      hact_d;
    logic [15:0]      line_base_d;
    logic             sof_pend_d;
    logic [OSIZE-1:0] word_d;

    // A SOF beat restarts the frame: the effective (_d) counters below are what the
    // current beat sees after any restart is applied.
    always_comb begin
        out_free    = !o_valid_q || o_ready;
        accept      = s_axis_tvalid && out_free;
        sof_beat    = accept && s_axis_tuser;
        take        = enable && accept && ((state_q == PACK) || s_axis_tuser);
        early_sof   = enable && sof_beat && (state_q == PACK) &&
                      ((slot_q != '0) || (linepix_q != '0));
        slot_d      = sof_beat ? '0 : slot_q;
        linepix_d   = sof_beat ? '0 : linepix_q;
        hact_d      = sof_beat ? hactive : hact_q;
        line_base_d = sof_beat ? '0 : line_cnt_q;
        sof_pend_d  = sof_beat ? 1'b1 : sof_pend_q;
        word_d      = sof_beat ? '0 : acc_q;
        for (int k = 0; k < PPW; k++) begin
            if (k == int'(slot_d)) begin
                word_d[k*DSIZE +: DSIZE] = s_axis_tdata;
            end
        end
        complete    = take && ((slot_d == NSIZE'(PPW - 1)) || s_axis_tlast);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= WAIT_SOF;
            acc_q      <= '0;
            slot_q     <= '0;
            linepix_q  <= '0;
            hact_q     <= '0;
            line_cnt_q <= '0;
            sof_pend_q <= 1'b0;
            o_data_q   <= '0;
            o_valid_q  <= 1'b0;
            o_npix_q   <= '0;
            o_sof_q    <= 1'b0;
            o_eol_q    <= 1'b0;
            err_len_q  <= 1'b0;
            err_sof_q  <= 1'b0;
        end else begin
            err_len_q <= 1'b0;
            err_sof_q <= 1'b0;
            if (o_valid_q && o_ready) begin
                o_valid_q <= 1'b0;
            end
            if (!enable) begin
                // Abandon the frame; an already-presented word stays put.
                state_q   <= WAIT_SOF;
                acc_q     <= '0;
                slot_q    <= '0;
                linepix_q <= '0;
            end else if (take) begin
                state_q   <= PACK;
                hact_q    <= hact_d;
                err_sof_q <= early_sof;
                if (complete) begin
                    o_valid_q  <= 1'b1;
                    o_data_q   <= word_d;
                    o_npix_q   <= slot_d + NSIZE'(1);
                    o_eol_q    <= s_axis_tlast;
                    o_sof_q    <= sof_pend_d;
                    sof_pend_q <= 1'b0;
                    slot_q     <= '0;
                    acc_q      <= '0;
                end else begin
                    sof_pend_q <= sof_pend_d;
                    slot_q     <= slot_d + NSIZE'(1);
                    acc_q      <= word_d;
                end
                if (s_axis_tlast) begin
                    line_cnt_q <= line_base_d + 16'd1;
                    linepix_q  <= '0;
                    err_len_q  <= ((linepix_d + 16'd1) != hact_d);
                end else begin
                    line_cnt_q <= line_base_d;
                    linepix_q  <= linepix_d + 16'd1;
                end
            end
        end
    end

    assign s_axis_tready = out_free;
    assign o_data        = o_data_q;
    assign o_valid       = o_valid_q;
    assign o_npix        = o_npix_q;
    assign o_sof         = o_sof_q;
    assign o_eol         = o_eol_q;
    assign line_cnt      = line_cnt_q;
    assign err_line_len  = err_len_q;
    assign err_early_sof = err_sof_q;

endmodule

// File: tb/tb_axis_pixel_pack.sv
// Directed and randomized bench for axis_pixel_pack against a pixel-list reference model.
module tb_axis_pixel_pack;

    localparam int DSIZE = 24;
    localparam int OSIZE = 256;
    localparam int NSIZE = 8;
    localparam int PPW   = 10;

    typedef struct packed {
        logic [DSIZE-1:0] d;
        logic             u;
        logic             l;
    } beat_t;

    typedef struct packed {
        logic [OSIZE-1:0] d;
        logic [NSIZE-1:0] n;
        logic             s;
        logic             e;
    } word_t;

    logic             clock = 1'b0;
    logic             rst;
    logic             enable;
    logic [15:0]      hactive;
    logic [DSIZE-1:0] s_axis_tdata;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             s_axis_tuser;
    logic             s_axis_tlast;
    logic [OSIZE-1:0] o_data;
    logic             o_valid;
    logic             o_ready;
    logic [NSIZE-1:0] o_npix;
    logic             o_sof;
    logic             o_eol;
    logic [15:0]      line_cnt;
    logic             err_line_len;
    logic             err_early_sof;

    axis_pixel_pack #(.DSIZE(DSIZE), .OSIZE(OSIZE), .NSIZE(NSIZE)) dut (
        .clock(clock), .rst(rst), .enable(enable), .hactive(hactive),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser),
        .s_axis_tlast(s_axis_tlast), .o_data(o_data), .o_valid(o_valid),
        .o_ready(o_ready), .o_npix(o_npix), .o_sof(o_sof), .o_eol(o_eol),
        .line_cnt(line_cnt), .err_line_len(err_line_len), .err_early_sof(err_early_sof)
    );

    always #5 clock = ~clock;

    int               checks = 0;
    int               errors = 0;
    int               n_len_err = 0;
    int               n_sof_err = 0;
    beat_t            bq[$];
    word_t            expq[$];
    word_t            gotq[$];
    logic [DSIZE-1:0] cur[$];
    bit               m_in_frame, m_pend, m_err_len, m_err_sof, m_complete;
    int               m_lp, m_hact;
    logic [15:0]      m_line_cnt;
    bit               last_v, last_r;
    logic [OSIZE-1:0] last_d;

    task automatic chk(input string tag, input logic [OSIZE-1:0] got, input logic [OSIZE-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0; m_pend = 0; m_err_len = 0; m_err_sof = 0; m_complete = 0;
        m_lp = 0; m_hact = 0; m_line_cnt = '0;
        cur.delete(); expq.delete(); bq.delete();
        last_v = 0; last_r = 0; last_d = '0;
    endtask

    // Reference: collect accepted pixels of the current frame into a list and emit a
    // word whenever the list holds PPW pixels or the line ends.
    task automatic model_beat(input beat_t b);
        word_t w;
        if (!m_in_frame && !b.u) return;
        if (b.u) begin
            if (m_in_frame && (cur.size() > 0 || m_lp > 0)) m_err_sof = 1;
            cur.delete();
            m_lp = 0; m_hact = int'(hactive); m_line_cnt = '0; m_pend = 1; m_in_frame = 1;
        end
        cur.push_back(b.d);
        m_lp++;
        if (cur.size() == PPW || b.l) begin
            w = '0;
            for (int k = 0; k < cur.size(); k++) w.d[k*DSIZE +: DSIZE] = cur[k];
            w.n = NSIZE'(cur.size());
            w.e = b.l;
            w.s = m_pend;
            m_pend = 0;
            expq.push_back(w);
            cur.delete();
            m_complete = 1;
        end
        if (b.l) begin
            m_line_cnt++;
            if (m_lp != m_hact) m_err_len = 1;
            m_lp = 0;
        end
    endtask

    // One clock: check at the falling edge, update the model for the upcoming rising edge.
    task automatic step();
        word_t w, g;
        @(negedge clock);
        chk("line_cnt", line_cnt, m_line_cnt);
        chk("err_line_len", err_line_len, m_err_len);
        chk("err_early_sof", err_early_sof, m_err_sof);
        if (m_complete) chk("latency_valid", o_valid, 1);
        chk("tready", s_axis_tready, !o_valid || o_ready);
        if (last_v && !last_r) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_data", o_data, last_d);
        end
        if (err_line_len === 1'b1) n_len_err++;
        if (err_early_sof === 1'b1) n_sof_err++;
        if (o_valid && o_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_word: observed npix %0d expected no word", o_npix);
            end else begin
                w = expq.pop_front();
                chk("o_data", o_data, w.d);
                chk("o_npix", o_npix, w.n);
                chk("o_sof", o_sof, w.s);
                chk("o_eol", o_eol, w.e);
                g.d = o_data; g.n = o_npix; g.s = o_sof; g.e = o_eol;
                gotq.push_back(g);
            end
        end
        last_v = o_valid; last_r = o_ready; last_d = o_data;
        m_err_len = 0; m_err_sof = 0; m_complete = 0;
        if (!enable) begin
            m_in_frame = 0; cur.delete(); m_lp = 0;
        end else if (s_axis_tvalid && s_axis_tready) begin
            model_beat(bq[0]);
            void'(bq.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    // mode 0: ready always high; 1: random ready/valid; 2: periodic 5-cycle output stalls
    task automatic run(input int mode, input int maxc);
        int n = 0;
        while ((bq.size() > 0 || expq.size() > 0 || o_valid === 1'b1) && n < maxc) begin
            if (bq.size() > 0) begin
                s_axis_tvalid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_axis_tdata  = bq[0].d;
                s_axis_tuser  = bq[0].u;
                s_axis_tlast  = bq[0].l;
            end else begin
                s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
            end
            case (mode)
                0:       o_ready = 1;
                1:       o_ready = ($urandom_range(0, 2) != 0);
                default: o_ready = ((n % 12) >= 5);
            endcase
            step();
            n++;
        end
        chk("run_done", (n < maxc), 1);
        s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0; o_ready = 1;
    endtask

    task automatic add_line(input int len, input int start, input bit sof, input bit last, input bit rnd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = rnd ? DSIZE'($urandom) : DSIZE'(start + i);
            b.u = sof && (i == 0);
            b.l = last && (i == len - 1);
            bq.push_back(b);
        end
    endtask

    initial begin
        int e0, len;
        rst = 1; enable = 1; hactive = 16'd20; o_ready = 0;
        s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tuser = 0; s_axis_tlast = 0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_npix", o_npix, 0);
        chk("rst_sof_eol", {o_sof, o_eol}, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_errs", {err_line_len, err_early_sof}, 0);
        chk("rst_tready", s_axis_tready, 1);
        rst = 0;
        @(posedge clock);
        #1;

        // One 20-pixel line, two full words.
        hactive = 16'd20;
        gotq.delete();
        add_line(20, 1, 1, 1, 0);
        run(0, 200);
        chk("a_nwords", gotq.size(), 2);
        if (gotq.size() == 2) begin
            chk("a_npix", {gotq[0].n, gotq[1].n}, {8'd10, 8'd10});
            chk("a_sof", {gotq[0].s, gotq[1].s}, 2'b10);
            chk("a_eol", {gotq[0].e, gotq[1].e}, 2'b01);
            chk("a_w0_px0", gotq[0].d[23:0], 1);
            chk("a_w0_px9", gotq[0].d[239:216], 10);
            chk("a_w0_pad", gotq[0].d[255:240], 0);
        end

        // 25-pixel line ends in a half word.
        hactive = 16'd25;
        gotq.delete();
        add_line(25, 101, 1, 1, 0);
        run(1, 400);
        chk("b_nwords", gotq.size(), 3);
        if (gotq.size() == 3) begin
            chk("b_npix", {gotq[0].n, gotq[1].n, gotq[2].n}, {8'd10, 8'd10, 8'd5});
            chk("b_eol", gotq[2].e, 1);
            chk("b_upper_zero", gotq[2].d[255:120], 0);
        end
        chk("b_line_cnt", line_cnt, 1);

        // Output stalls of 5 cycles with pixels streaming.
        hactive = 16'd30;
        add_line(30, 200, 1, 1, 0);
        run(2, 400);

        // Short line: tlast on pixel 19 of 20.
        hactive = 16'd20;
        gotq.delete();
        e0 = n_len_err;
        add_line(19, 300, 1, 1, 0);
        run(0, 200);
        chk("d_len_err_pulses", n_len_err - e0, 1);
        if (gotq.size() == 2) chk("d_last_word", {gotq[1].n, gotq[1].e}, {8'd9, 1'b1});

        // SOF arriving on the 7th pixel of a line.
        gotq.delete();
        e0 = n_sof_err;
        add_line(20, 400, 1, 1, 0);
        add_line(6, 500, 0, 0, 0);
        add_line(20, 600, 1, 1, 0);
        run(1, 600);
        chk("e_sof_err_pulses", n_sof_err - e0, 1);
        chk("e_nwords", gotq.size(), 4);
        if (gotq.size() == 4) chk("e_restart_word", {gotq[2].s, gotq[2].d[23:0]}, {1'b1, 24'd600});

        // Reset with four pixels sitting in the accumulator.
        add_line(4, 700, 1, 0, 0);
        run(0, 100);
        rst = 1;
        @(posedge clock);
        #1;
        rst = 0;
        @(negedge clock);
        chk("f_o_valid", o_valid, 0);
        chk("f_tready", s_axis_tready, 1);
        chk("f_line_cnt", line_cnt, 0);
        model_reset();
        @(posedge clock);
        #1;
        gotq.delete();
        add_line(3, 800, 0, 0, 0);
        add_line(20, 900, 1, 1, 0);
        run(1, 400);
        chk("f_nwords", gotq.size(), 2);
        if (gotq.size() == 2) chk("f_first_px", {gotq[0].s, gotq[0].d[23:0]}, {1'b1, 24'd900});

        // Drop enable mid-line, then restart on the next SOF.
        add_line(5, 1000, 1, 0, 0);
        run(0, 100);
        enable = 0;
        step();
        enable = 1;
        gotq.delete();
        add_line(20, 1100, 1, 1, 0);
        run(1, 400);
        chk("g_nwords", gotq.size(), 2);
        if (gotq.size() == 2) chk("g_first_px", {gotq[0].s, gotq[0].d[23:0]}, {1'b1, 24'd1100});

        // Random frames: odd line lengths, stray pre-SOF partial lines, random handshakes.
        for (int f = 0; f < 6; f++) begin
            hactive = 16'($urandom_range(1, 30));
            if ($urandom_range(0, 2) == 0) add_line($urandom_range(1, 5), 0, 0, 0, 1);
            for (int ln = 0; ln < 3; ln++) begin
                len = int'(hactive) + $urandom_range(0, 2) - 1;
                if (len < 1) len = 1;
                add_line(len, 0, (ln == 0), 1, 1);
            end
            run(1, 2000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
